// File: rtl/csat_bench_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csat_bench_pkg
// Description : Shared types and default widths for the CSAT benchmark
//               helper blocks (factor search engine and its multiplier).
//               Contents: fse_state_t (factor search FSM state encoding),
//               A_W_DEF / B_W_DEF (default factor widths).
// Revision    : 1.0 - initial release
// ============================================================================
package csat_bench_pkg;

  localparam int A_W_DEF = 7;
  localparam int B_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    MUL   = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } fse_state_t;

endpackage : csat_bench_pkg
`default_nettype wire

// File: rtl/mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : mult_shift_add
// Description : Radix-2 shift-add unsigned multiplier, one multiplier bit per
//               cycle. Bit 0 is folded in on the start cycle, so the full
//               product is ready B_W cycles after start, qualified by a
//               one-cycle done pulse. prod holds until the next start.
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               start - load a/b and begin a multiply
//               a     - multiplicand (A_W bits)
//               b     - multiplier   (B_W bits)
//               done  - one-cycle pulse, prod is final
//               prod  - full-width product (A_W+B_W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_shift_add #(
  parameter  int A_W = 7,
  parameter  int B_W = 4,
  localparam int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           done,
  output logic [P_W-1:0] prod
);

  localparam int CW = $clog2(B_W + 1);

  logic [P_W-1:0] acc_q;
  logic [P_W-1:0] mcand_q;
  logic [B_W-1:0] mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q;
  logic           done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        // Bit 0 is accumulated on the load edge; the remaining B_W-1 bits
        // follow one per cycle, giving exactly B_W cycles to done.
        acc_q    <= b[0] ? P_W'(a) : '0;
        mcand_q  <= P_W'(a) << 1;
        mplier_q <= b >> 1;
        cnt_q    <= CW'(B_W - 1);
        run_q    <= (B_W > 1);
        done_q   <= (B_W == 1);
      end else if (run_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign prod = acc_q;

endmodule : mult_shift_add
`default_nettype wire

// File: rtl/factor_search_engine.sv
`default_nettype none
// ============================================================================
// Module      : factor_search_engine
// Description : Sequential brute-force factoring of a target T into a*b with
//               a>=2, b>=2. b is the outer (ascending) loop, a the inner one;
//               a row ends early once a*b exceeds T. Reports SAT/UNSAT, the
//               first witness in search order and the candidate count.
// Ports       : clk        - clock, rising edge
//               reset      - synchronous active-high reset, aborts a search
//               start      - request pulse, accepted only when idle
//               target     - product to factor, latched on accept
//               busy       - search in progress
//               done       - one-cycle completion pulse
//               found      - 1 = SAT, 0 = UNSAT
//               a_out      - witness a (0 when not found)
//               b_out      - witness b (0 when not found)
//               cand_count - candidate pairs multiplied in last search
// Revision    : 1.0 - initial release
// ============================================================================
module factor_search_engine
  import csat_bench_pkg::*;
#(
  parameter  int A_W = A_W_DEF,
  parameter  int B_W = B_W_DEF,
  localparam int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [P_W-1:0] target,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [A_W-1:0] a_out,
  output logic [B_W-1:0] b_out,
  output logic [P_W-1:0] cand_count
);

  localparam logic [A_W-1:0] A_MAX = '1;
  localparam logic [B_W-1:0] B_MAX = '1;
  localparam logic [A_W-1:0] A_TWO = A_W'(2);
  localparam logic [B_W-1:0] B_TWO = B_W'(2);

  fse_state_t     state_q, state_d;
  logic [P_W-1:0] target_q, target_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [P_W-1:0] cand_q, cand_d;
  logic           found_q, found_d;
  logic [A_W-1:0] a_out_q, a_out_d;
  logic [B_W-1:0] b_out_q, b_out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           mult_start;
  logic           mult_done;
  logic [P_W-1:0] mult_prod;
  logic           accept;

  mult_shift_add #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mult (
    .clk   (clk),
    .reset (reset),
    .start (mult_start),
    .a     (a_q),
    .b     (b_q),
    .done  (mult_done),
    .prod  (mult_prod)
  );

  // done is registered one cycle after FIN, so the engine is already in IDLE
  // while done is high; masking accept with done keeps a start coincident
  // with done from being taken.
  assign accept = (state_q == IDLE) && start && !done_q;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    a_d        = a_q;
    b_d        = b_q;
    cand_d     = cand_q;
    found_d    = found_q;
    a_out_d    = a_out_q;
    b_out_d    = b_out_q;
    mult_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = target;
          a_d      = A_TWO;
          b_d      = B_TWO;
          cand_d   = '0;
          found_d  = 1'b0;
          a_out_d  = '0;
          b_out_d  = '0;
          // Targets below 4 cannot have two factors >= 2.
          state_d  = (target < P_W'(4)) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        cand_d     = cand_q + 1'b1;
        state_d    = MUL;
      end
      MUL: begin
        if (mult_done) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mult_prod == target_q) begin
          found_d = 1'b1;
          a_out_d = a_q;
          b_out_d = b_q;
          state_d = FIN;
        end else if ((mult_prod > target_q) || (a_q == A_MAX)) begin
          // Row exhausted: a only grows, so a larger product ends this b.
          if (b_q == B_MAX) begin
            state_d = FIN;
          end else begin
            b_d     = b_q + 1'b1;
            a_d     = A_TWO;
            state_d = ISSUE;
          end
        end else begin
          a_d     = a_q + 1'b1;
          state_d = ISSUE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cand_q   <= '0;
      found_q  <= 1'b0;
      a_out_q  <= '0;
      b_out_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cand_q   <= cand_d;
      found_q  <= found_d;
      a_out_q  <= a_out_d;
      b_out_q  <= b_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign a_out      = a_out_q;
  assign b_out      = b_out_q;
  assign cand_count = cand_q;

endmodule : factor_search_engine
`default_nettype wire

// File: tb/tb_factor_search_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_factor_search_engine
// Description : Self-checking bench for factor_search_engine. Expected
//               results come from a reference search model, are queued when
//               a start is accepted and compared when done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_factor_search_engine;

  localparam int A_W = 7;
  localparam int B_W = 4;
  localparam int P_W = A_W + B_W;
  localparam int BUDGET = 20000;

  typedef struct {
    int found;
    int a;
    int b;
    int cand;
    int lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [P_W-1:0] target;
  logic           busy;
  logic           done;
  logic           found;
  logic [A_W-1:0] a_out;
  logic [B_W-1:0] b_out;
  logic [P_W-1:0] cand_count;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  factor_search_engine #(
    .A_W (A_W),
    .B_W (B_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .target     (target),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .a_out      (a_out),
    .b_out      (b_out),
    .cand_count (cand_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference search: b outer, a inner, row pruned once a*b exceeds t.
  function automatic exp_t model(input int t);
    exp_t e;
    int   n;
    e = '{found: 0, a: 0, b: 0, cand: 0, lat: 0};
    n = 0;
    if (t >= 4) begin
      for (int b = 2; b < (1 << B_W) && e.found == 0; b++) begin
        for (int a = 2; a < (1 << A_W); a++) begin
          n++;
          if (a * b == t) begin
            e.found = 1;
            e.a     = a;
            e.b     = b;
            break;
          end
          if (a * b > t) break;
        end
      end
    end
    e.cand = n;
    e.lat  = 1 + n * (B_W + 2) + 1;
    return e;
  endfunction

  // One search. Cycle 0 is the cycle in which start is accepted; k counts
  // cycles after it, sampled on the falling edge.
  task automatic run(input string tag, input int t, input bit mid_start,
                     input bit start_at_done);
    exp_t e;
    exp_t g;
    int   k;
    bit   seen;
    @(negedge clk);
    start  = 1'b1;
    target = P_W'(t);
    @(posedge clk);
    sb.push_back(model(t));
    @(negedge clk);
    start  = 1'b0;
    target = '1;
    check({tag, "_busy_c1"}, int'(busy), 1);
    k    = 1;
    seen = 1'b0;
    while (!seen && k < BUDGET) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        start = (mid_start && k == 50);
        if (start) target = P_W'(6);
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, int'(seen), 1);
    if (seen && sb.size() != 0) begin
      g = sb.pop_front();
      check({tag, "_found"},   int'(found),      g.found);
      check({tag, "_a_out"},   int'(a_out),      g.a);
      check({tag, "_b_out"},   int'(b_out),      g.b);
      check({tag, "_cand"},    int'(cand_count), g.cand);
      check({tag, "_latency"}, k,                g.lat);
      check({tag, "_busy_done"}, int'(busy),     0);
      if (start_at_done) begin
        start  = 1'b1;
        target = P_W'(6);
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_pulse"}, int'(done), 0);
      if (start_at_done) check({tag, "_start_at_done_ignored"}, int'(busy), 0);
    end else if (sb.size() != 0) begin
      e = sb.pop_front();
    end
  endtask

  initial begin
    int n_done;
    reset  = 1'b1;
    start  = 1'b0;
    target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy",  int'(busy),       0);
    check("rst_done",  int'(done),       0);
    check("rst_found", int'(found),      0);
    check("rst_a_out", int'(a_out),      0);
    check("rst_b_out", int'(b_out),      0);
    check("rst_cand",  int'(cand_count), 0);

    // Smallest composite with a hit on the second candidate.
    run("t6", 6, 1'b0, 1'b0);
    // Outputs hold after the search completes.
    repeat (5) @(negedge clk);
    check("t6_hold_found", int'(found), 1);
    check("t6_hold_a",     int'(a_out), 3);

    run("t143",  143, 1'b0, 1'b0);
    run("t211",  211, 1'b0, 1'b0);
    run("t3",    3,   1'b0, 1'b0);
    run("t0",    0,   1'b0, 1'b1);
    run("t1905", 1905, 1'b1, 1'b0);

    // Reset while the multiplier is running during a 143 search.
    @(negedge clk);
    start  = 1'b1;
    target = P_W'(143);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_pre", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",  int'(busy),       0);
    check("abort_done",  int'(done),       0);
    check("abort_found", int'(found),      0);
    check("abort_a_out", int'(a_out),      0);
    check("abort_b_out", int'(b_out),      0);
    check("abort_cand",  int'(cand_count), 0);
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_idle", int'(busy), 0);

    run("t6_again", 6, 1'b0, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_factor_search_engine
`default_nettype wire
